// File: rtl/fetch_queue.sv
// Fetch PC generator feeding an in-order queue of up to DEPTH in-flight/buffered instructions.
// Latency: request one cycle after reset release; response visible to ID the cycle after it returns.
// Backpressure: id_ready low holds the head; req_valid drops once alloc + drop_cnt reaches DEPTH.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] INIT_PC    = 32'hBFC00000,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_data,
  output logic                  inst_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] inst
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic                  run_q, run_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  ptr_t                  head_q, head_d;
  ptr_t                  fill_q, fill_d;
  ptr_t                  tail_q, tail_d;
  ptr_t                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_d   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      filled_q, filled_d;

  ptr_t        alloc, pend;
  logic [PW:0] used;
  logic [IW-1:0] head_idx, fill_idx, tail_idx;
  logic        acc, resp_drop, resp_fill, resp_any, deq, redirect;

  // Occupancy and handshake decode from registered state only (no id_ready -> req_valid path)
  always_comb begin
    alloc     = tail_q - head_q;
    pend      = tail_q - fill_q;
    used      = {1'b0, alloc} + {1'b0, drop_q};
    head_idx  = head_q[IW-1:0];
    fill_idx  = fill_q[IW-1:0];
    tail_idx  = tail_q[IW-1:0];
    req_valid = run_q && (used < DEPTH_W);
    req_addr  = fpc_q;
    inst_valid = (alloc != '0) && filled_q[head_idx];
    inst_pc    = pc_q[head_idx];
    inst       = data_q[head_idx];
    acc       = req_valid && req_ready;
    // Responses owed to a killed stream are consumed first; a stray response with nothing owed is ignored
    resp_drop = resp_valid && (drop_q != '0);
    resp_fill = resp_valid && (drop_q == '0) && (pend != '0);
    resp_any  = resp_drop || resp_fill;
    deq       = inst_valid && id_ready;
    redirect  = flush || branch_flag;
  end

  // Next-state: allocate, fill, dequeue, then let a redirect override pointers and PC
  always_comb begin
    run_d    = 1'b1;
    fpc_d    = fpc_q;
    head_d   = head_q;
    fill_d   = fill_q;
    tail_d   = tail_q;
    drop_d   = drop_q;
    pc_d     = pc_q;
    data_d   = data_q;
    filled_d = filled_q;

    if (acc) begin
      pc_d[tail_idx]     = fpc_q;
      filled_d[tail_idx] = 1'b0;
      tail_d             = tail_q + ptr_t'(1);
      fpc_d              = fpc_q + ADDR_WIDTH'(4);
    end

    if (resp_drop) begin
      drop_d = drop_q - ptr_t'(1);
    end

    // fill_idx == tail_idx only when pend is 0 or DEPTH; neither allows both writes at once
    if (resp_fill) begin
      data_d[fill_idx]   = resp_data;
      filled_d[fill_idx] = 1'b1;
      fill_d             = fill_q + ptr_t'(1);
    end

    if (deq) begin
      head_d = head_q + ptr_t'(1);
    end

    // Everything in flight, including this cycle's accept, now belongs to the dead stream
    if (redirect) begin
      fpc_d  = flush ? exc_pc : branch_addr;
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      drop_d = drop_q + pend + ptr_t'(acc) - ptr_t'(resp_any);
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      fpc_q    <= INIT_PC;
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      run_q    <= run_d;
      fpc_q    <= fpc_d;
      head_q   <= head_d;
      fill_q   <= fill_d;
      tail_q   <= tail_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
      pc_q     <= pc_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table-driven first-fetch vectors, hand sequences for corner cases,
// and a randomised run against a queue-based memory/ID model.
// Memory model returns wfn(addr) in request order with per-request latency.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] INIT_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid;
  logic        id_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst;

  fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INIT_PC(INIT_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .exc_pc(exc_pc),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .id_ready(id_ready), .inst_pc(inst_pc), .inst(inst)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] dat; int due; bit live; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] dat; bit filled; } ent_t;
  typedef struct { bit rr; bit ir; bit rv; logic [31:0] addr; bit iv; logic [31:0] ipc; } vec_t;

  mreq_t       mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] model_fpc;
  bit          run_m;
  int          cyc = 0;
  int          nvec = 0;
  int          nfail = 0;

  function automatic logic [31:0] wfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Compare current outputs with the model, drive this cycle's inputs, advance model and clock
  task automatic cyc_step(input bit rr, input bit ir, input bit fl, input logic [31:0] ep,
                          input bit br, input logic [31:0] ba, input int lat);
    int    dead;
    bit    rv_m, iv_m, acc, redir, found;
    mreq_t m;
    ent_t  e;
    dead = 0;
    foreach (mem_q[i]) if (!mem_q[i].live) dead++;
    rv_m = run_m && ((exp_q.size() + dead) < DEPTH);
    iv_m = (exp_q.size() > 0) && exp_q[0].filled;
    check("req_valid", {31'b0, req_valid}, {31'b0, rv_m});
    check("req_addr", req_addr, model_fpc);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, iv_m});
    if (iv_m) begin
      check("inst_pc", inst_pc, exp_q[0].pc);
      check("inst", inst, exp_q[0].dat);
    end

    resp_valid  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    resp_data   = resp_valid ? mem_q[0].dat : 32'h0;
    req_ready   = rr;
    id_ready    = ir;
    flush       = fl;
    exc_pc      = ep;
    branch_flag = br;
    branch_addr = ba;

    redir = fl || br;
    acc   = rv_m && rr;
    if (resp_valid) begin
      m = mem_q.pop_front();
      if (m.live) begin
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!found && !exp_q[i].filled) begin
            exp_q[i].filled = 1'b1;
            exp_q[i].dat    = m.dat;
            found = 1'b1;
          end
        end
        if (!found) begin
          nfail++;
          $display("FAIL protocol: response with nothing outstanding (cycle %0d)", cyc);
        end
      end
    end
    if (acc) begin
      m.addr = model_fpc; m.dat = wfn(model_fpc); m.due = cyc + lat; m.live = 1'b1;
      mem_q.push_back(m);
      e.pc = model_fpc; e.dat = '0; e.filled = 1'b0;
      exp_q.push_back(e);
      model_fpc = model_fpc + 32'd4;
    end
    if (iv_m && ir && !redir) void'(exp_q.pop_front());
    if (redir) begin
      model_fpc = fl ? ep : ba;
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].live = 1'b0;
    end
    run_m = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input bit rr, input bit ir, input int lat);
    cyc_step(rr, ir, 1'b0, 32'h0, 1'b0, 32'h0, lat);
  endtask

  // Hold reset over two edges, check cleared outputs, then release mid-cycle
  task automatic do_reset();
    rst = 1'b0;
    resp_valid = 1'b0; req_ready = 1'b0; id_ready = 1'b0;
    flush = 1'b0; branch_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {31'b0, req_valid}, 32'h0);
    check("rst_req_addr", req_addr, INIT_PC);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    mem_q.delete();
    exp_q.delete();
    model_fpc = INIT_PC;
    run_m = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   n;
    bit   rr, ir, fl, br;
    tbl[0] = '{rr:1, ir:1, rv:0, addr:32'hBFC00000, iv:0, ipc:32'h0};
    tbl[1] = '{rr:1, ir:1, rv:1, addr:32'hBFC00000, iv:0, ipc:32'h0};
    tbl[2] = '{rr:1, ir:1, rv:1, addr:32'hBFC00004, iv:0, ipc:32'h0};
    tbl[3] = '{rr:1, ir:1, rv:1, addr:32'hBFC00008, iv:1, ipc:32'hBFC00000};
    tbl[4] = '{rr:1, ir:1, rv:1, addr:32'hBFC0000C, iv:1, ipc:32'hBFC00004};
    tbl[5] = '{rr:1, ir:1, rv:1, addr:32'hBFC00010, iv:1, ipc:32'hBFC00008};

    @(posedge clk);
    #1;
    do_reset();

    // Reset release and first fetch, 1-cycle memory
    for (int i = 0; i < 6; i++) begin
      check("tbl_req_valid", {31'b0, req_valid}, {31'b0, tbl[i].rv});
      check("tbl_req_addr", req_addr, tbl[i].addr);
      check("tbl_inst_valid", {31'b0, inst_valid}, {31'b0, tbl[i].iv});
      if (tbl[i].iv) check("tbl_inst_pc", inst_pc, tbl[i].ipc);
      step(tbl[i].rr, tbl[i].ir, 1);
    end

    // Back-pressure: ID stalled from release, exactly DEPTH accepts
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid) n++;
      step(1'b1, 1'b0, 1);
    end
    check("bp_accepts", n, DEPTH);
    check("bp_req_valid_full", {31'b0, req_valid}, 32'h0);
    check("bp_head_valid", {31'b0, inst_valid}, 32'h1);
    step(1'b1, 1'b1, 1);
    check("bp_req_valid_after_deq", {31'b0, req_valid}, 32'h1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1);

    // Branch redirect with three requests owed by a 3-cycle memory
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3);
    cyc_step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80000100, 3);
    check("br_req_addr", req_addr, 32'h80000100);
    check("br_req_valid", {31'b0, req_valid}, 32'h1);
    for (int k = 0; k < 40 && !inst_valid; k++) step(1'b1, 1'b1, 3);
    check("br_first_valid", {31'b0, inst_valid}, 32'h1);
    check("br_first_pc", inst_pc, 32'h80000100);
    check("br_first_inst", inst, wfn(32'h80000100));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3);

    // Flush and branch together, with same-cycle accept, response and dequeue
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2);
    cyc_step(1'b1, 1'b1, 1'b1, 32'hBFC00380, 1'b1, 32'h80000000, 2);
    check("fl_req_addr", req_addr, 32'hBFC00380);
    for (int k = 0; k < 40 && !inst_valid; k++) step(1'b1, 1'b1, 2);
    check("fl_first_valid", {31'b0, inst_valid}, 32'h1);
    check("fl_first_pc", inst_pc, 32'hBFC00380);
    check("fl_first_inst", inst, wfn(32'hBFC00380));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 2);

    // Randomised stalls, latency and redirects
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 99) == 0);
      br = ($urandom_range(0, 49) == 0);
      cyc_step(rr, ir, fl, $urandom & 32'hFFFFFFFC, br, $urandom & 32'hFFFFFFFC,
               int'($urandom_range(1, 5)));
    end

    // Mid-stream reset with the queue full: outputs clear without a clock edge
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1);
    check("mr_full_inst_valid", {31'b0, inst_valid}, 32'h1);
    #3;
    rst = 1'b0;
    #1;
    check("mr_async_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("mr_async_req_valid", {31'b0, req_valid}, 32'h0);
    check("mr_async_inst_pc", inst_pc, 32'h0);
    @(posedge clk);
    #1;
    do_reset();
    for (int k = 0; k < 10 && !req_valid; k++) step(1'b1, 1'b1, 1);
    check("mr_restart_valid", {31'b0, req_valid}, 32'h1);
    check("mr_restart_addr", req_addr, INIT_PC);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
